// File: rtl/clint_pkg.sv
// Shared CLINT definitions: arbiter FSM states, register map offsets and tuning constants.
package clint_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  localparam logic [31:0] CLINT_BASE      = 32'h0200_0000;
  localparam logic [31:0] MSIP_OFFSET     = 32'h0000_0000;
  localparam logic [31:0] MTIMECMP_OFFSET = 32'h0000_4000;
  localparam logic [31:0] MTIME_OFFSET    = 32'h0000_BFF8;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;
  localparam int LOCK_MAX_BURST         = 4;

  // (base + off) mod n, assuming base < n and off < n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first request at or after the pointer; the pointer
// moves past the winner only when the caller strobes advance_i.
module rr_arbiter
  import clint_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;

  // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
  always_comb begin
    idx_o   = ptr_q;
    valid_o = 1'b0;
    gnt_o   = '0;
    cand    = '0;
    // Walk from farthest to nearest so the nearest requester at/after ptr wins last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = IDX_W'(wrap_idx(int'(ptr_q), i, NUM_REQ));
      if (req_i[cand]) begin
        idx_o   = cand;
        valid_o = 1'b1;
      end
    end
    if (valid_o) gnt_o[idx_o] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (advance_i && valid_o) begin
      ptr_q <= (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/clint_arbiter.sv
// Shares the CLINT slave port among NUM_REQ requesters with round-robin grant and a
// no-response watchdog. Optional CLINT_ARB_LOCK_EN adds lock_i for short atomic bursts.
module clint_arbiter
  import clint_pkg::*;
#(
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  localparam int IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [NUM_REQ-1:0]    we_i,
  input  logic [NUM_REQ*32-1:0] addr_i,
  input  logic [NUM_REQ*32-1:0] wdata_i,
  input  logic [NUM_REQ*4-1:0]  be_i,
`ifdef CLINT_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]    lock_i,
`endif
  output logic [NUM_REQ-1:0]    ready_o,
  output logic [NUM_REQ-1:0]    err_o,
  output logic [31:0]           rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic [3:0]            mem_be_o,
  input  logic [31:0]           mem_rdata_i,
  input  logic                  mem_ready_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] gnt_oh_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;
  logic               lock_hit;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_oh;
  logic               grant_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .advance_i ((state_q == IDLE) && !lock_hit),
    .gnt_o     (arb_gnt),
    .idx_o     (arb_idx),
    .valid_o   (arb_valid)
  );

`ifdef CLINT_ARB_LOCK_EN
  localparam int BURST_W = $clog2(LOCK_MAX_BURST + 1);

  logic [IDX_W-1:0]   gnt_idx_q;
  logic               lock_q;
  logic [BURST_W-1:0] burst_q;

  // Re-grant the previous owner only in the IDLE cycle right after its locked response.
  assign lock_hit = (state_q == IDLE) && lock_q && |(req_i & gnt_oh_q) &&
                    (burst_q < BURST_W'(LOCK_MAX_BURST));
  assign sel_idx  = lock_hit ? gnt_idx_q : arb_idx;
  assign sel_oh   = lock_hit ? gnt_oh_q  : arb_gnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_idx_q <= '0;
      lock_q    <= 1'b0;
      burst_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          lock_q <= 1'b0;
          if (grant_any) begin
            gnt_idx_q <= sel_idx;
            burst_q   <= lock_hit ? burst_q + 1'b1 : BURST_W'(1);
          end
        end
        RESP:    lock_q <= |(lock_i & gnt_oh_q);
        default: ;
      endcase
    end
  end
`else
  assign lock_hit = 1'b0;
  assign sel_idx  = arb_idx;
  assign sel_oh   = arb_gnt;
`endif

  assign grant_any = arb_valid || lock_hit;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the latched transaction fields are reset too, so mem_*_o read 0 out of reset.
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_oh_q    <= '0;
      ready_o     <= '0;
      err_o       <= '0;
      rdata_o     <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_any) begin
            gnt_oh_q    <= sel_oh;
            mem_we_o    <= we_i[sel_idx];
            mem_addr_o  <= addr_i[32*sel_idx +: 32];
            mem_wdata_o <= wdata_i[32*sel_idx +: 32];
            mem_be_o    <= be_i[4*sel_idx +: 4];
            mem_req_o   <= 1'b1;
            cnt_q       <= '0;
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            ready_o   <= gnt_oh_q;
            err_o     <= '0;
            rdata_o   <= mem_we_o ? '0 : mem_rdata_i;
            state_q   <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_req_o <= 1'b0;
            ready_o   <= gnt_oh_q;
            err_o     <= gnt_oh_q;
            rdata_o   <= '0;
            state_q   <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          ready_o <= '0;
          err_o   <= '0;
          rdata_o <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clint_arbiter.sv
// Directed bench for clint_arbiter: stimulus queues expected responses, a monitor checks them.
module tb_clint_arbiter;
  import clint_pkg::*;

  localparam int NUM_REQ        = 4;
  localparam int TIMEOUT_CYCLES = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [NUM_REQ-1:0]    req_i, we_i;
  logic [NUM_REQ*32-1:0] addr_i, wdata_i;
  logic [NUM_REQ*4-1:0]  be_i;
`ifdef CLINT_ARB_LOCK_EN
  logic [NUM_REQ-1:0]    lock_i;
`endif
  logic [NUM_REQ-1:0]    ready_o, err_o;
  logic [31:0]           rdata_o;
  logic                  mem_req_o, mem_we_o;
  logic [31:0]           mem_addr_o, mem_wdata_o;
  logic [3:0]            mem_be_o;
  logic [31:0]           mem_rdata_i;
  logic                  mem_ready_i;

  logic                  clint_en;
  logic [31:0]           clint_rdata;

  typedef struct {
    int          idx;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  clint_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
`ifdef CLINT_ARB_LOCK_EN
    .lock_i      (lock_i),
`endif
    .ready_o     (ready_o),
    .err_o       (err_o),
    .rdata_o     (rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_be_o    (mem_be_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ready_i (mem_ready_i)
  );

  // Zero-wait CLINT model; clint_en=0 models an unmapped address that never readies.
  assign mem_ready_i = mem_req_o & clint_en;
  assign mem_rdata_i = clint_rdata;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int k, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
    we_i[k]             = we;
    addr_i[32*k +: 32]  = a;
    wdata_i[32*k +: 32] = wd;
    be_i[4*k +: 4]      = be;
  endtask

  task automatic expect_resp(input int k, input logic e, input logic [31:0] d);
    exp_t x;
    x.idx   = k;
    x.err   = e;
    x.rdata = d;
    exp_q.push_back(x);
  endtask

  task automatic wait_ready(input int k, output int at_cyc);
    bit seen = 1'b0;
    at_cyc = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (ready_o[k]) begin
        seen   = 1'b1;
        at_cyc = cyc;
      end
    end
    check($sformatf("ready%0d_seen", k), 32'(seen), 32'd1);
  endtask

  // Monitor: every response the DUT presents is matched against the head of the queue.
  always @(negedge clk_i) begin
    if (ready_o != '0 || err_o != '0) begin
      if (exp_q.size() == 0) begin
        check("spurious_ready", 32'(ready_o), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("ready_oh_r%0d", e.idx), 32'(ready_o), 32'd1 << e.idx);
        check($sformatf("err_r%0d", e.idx), 32'(err_o), e.err ? (32'd1 << e.idx) : 32'd0);
        check($sformatf("rdata_r%0d", e.idx), rdata_o, e.rdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int t, t_prev, hi;
    bit seen;
    int order2[5] = '{0, 1, 2, 3, 0};
    int order7[$];

    rst_i = 1'b1; req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    clint_en = 1'b1; clint_rdata = '0;
`ifdef CLINT_ARB_LOCK_EN
    lock_i = '0;
`endif
    repeat (3) step();
    @(negedge clk_i);
    check("rst_mem_req", 32'(mem_req_o), 0);
    check("rst_ready", 32'(ready_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_fields", {mem_wdata_o[27:0], mem_be_o}, 0);
    step();
    rst_i = 1'b0;

    // Single read of mtime by requester 2: mem_req_o in cycle 1, ready_o in cycle 2.
    clint_rdata = 32'h0000_1234;
    set_req(2, 1'b0, CLINT_BASE + MTIME_OFFSET, 32'h0, 4'hF);
    req_i = 4'b0100;
    expect_resp(2, 1'b0, 32'h0000_1234);
    @(negedge clk_i); check("s1_c0_mem_req", 32'(mem_req_o), 0);
    @(negedge clk_i); check("s1_c1_mem_req", 32'(mem_req_o), 1);
    check("s1_c1_addr", mem_addr_o, 32'h0200_BFF8);
    check("s1_c1_we", 32'(mem_we_o), 0);
    @(negedge clk_i); check("s1_c2_ready", 32'(ready_o), 32'b0100);
    check("s1_c2_mem_req", 32'(mem_req_o), 0);
    step();
    req_i = '0;

    // All four requesting from reset: grant order 0,1,2,3,0, responses 3 cycles apart.
    rst_i = 1'b1;
    clint_rdata = 32'h5555_AAAA;
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, CLINT_BASE + MSIP_OFFSET + 32'(4*k), 32'h0, 4'hF);
    req_i = 4'b1111;
    step(); step();
    rst_i = 1'b0;
    foreach (order2[i]) expect_resp(order2[i], 1'b0, 32'h5555_AAAA);
    t_prev = 0;
    foreach (order2[i]) begin
      wait_ready(order2[i], t);
      if (i > 0) check("s2_spacing", 32'(t - t_prev), 32'd3);
      t_prev = t;
    end
    step();
    req_i = '0;

    // Write to an unmapped address: 16 ACCESS cycles, then an error response with rdata 0.
    clint_en = 1'b0;
    clint_rdata = 32'hBAD0_BAD0;
    set_req(1, 1'b1, 32'h0200_8000, 32'hCAFE_F00D, 4'hF);
    req_i = 4'b0010;
    expect_resp(1, 1'b1, 32'h0);
    hi = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk_i);
      if (mem_req_o) begin
        hi++;
        if (hi == 1) begin
          check("s3_we", 32'(mem_we_o), 1);
          check("s3_wdata", mem_wdata_o, 32'hCAFE_F00D);
        end
      end
      if (ready_o[1]) seen = 1'b1;
    end
    check("s3_ready_seen", 32'(seen), 1);
    check("s3_mem_req_cycles", 32'(hi), 32'd16);
    step();
    req_i = '0;

    // Reset in the second ACCESS cycle of requester 3 abandons it silently.
    set_req(3, 1'b0, CLINT_BASE + MTIMECMP_OFFSET, 32'h0, 4'hF);
    req_i = 4'b1000;
    @(negedge clk_i);
    @(negedge clk_i); check("s4_access", 32'(mem_req_o), 1);
    step();
    rst_i = 1'b1;
    req_i = '0;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("s4_mem_req_after_rst", 32'(mem_req_o), 0);
    check("s4_ready_after_rst", 32'(ready_o), 0);
    step();
    clint_en = 1'b1;
    clint_rdata = 32'h0000_00C3;
    set_req(0, 1'b0, CLINT_BASE + MSIP_OFFSET, 32'h0, 4'hF);
    req_i = 4'b1001;
    expect_resp(0, 1'b0, 32'h0000_00C3);
    expect_resp(3, 1'b0, 32'h0000_00C3);
    wait_ready(0, t); step(); req_i[0] = 1'b0;
    wait_ready(3, t); step(); req_i[3] = 1'b0;

    // Pointer returns to 0 on reset: after granting 0, reset, then 0 beats 1 again.
    req_i = 4'b0001;
    expect_resp(0, 1'b0, 32'h0000_00C3);
    wait_ready(0, t); step(); req_i = '0;
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    set_req(1, 1'b1, CLINT_BASE + MTIMECMP_OFFSET + 32'h8, 32'h1111_2222, 4'h3);
    req_i = 4'b0011;
    expect_resp(0, 1'b0, 32'h0000_00C3);
    expect_resp(1, 1'b0, 32'h0);
    wait_ready(0, t); step(); req_i[0] = 1'b0;
    wait_ready(1, t); step(); req_i[1] = 1'b0;

    // Requester 0 changes its fields mid-access; the CLINT must keep seeing the latched ones.
    clint_en = 1'b0;
    set_req(0, 1'b1, CLINT_BASE + MTIMECMP_OFFSET + 32'h4, 32'h1357_9BDF, 4'b1100);
    req_i = 4'b0001;
    expect_resp(0, 1'b1, 32'h0);
    @(negedge clk_i);
    @(negedge clk_i); check("s6_access", 32'(mem_req_o), 1);
    step();
    set_req(0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("s6_addr_held", mem_addr_o, 32'h0200_4004);
      check("s6_wdata_held", mem_wdata_o, 32'h1357_9BDF);
      check("s6_be_held", 32'(mem_be_o), 32'b1100);
      check("s6_we_held", 32'(mem_we_o), 1);
    end
    wait_ready(0, t); step(); req_i = '0;
    clint_en = 1'b1;

    // Two continuous requesters from a fresh pointer; requester 0 holds lock when enabled.
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    clint_rdata = 32'h0000_7777;
    set_req(0, 1'b0, CLINT_BASE + MTIME_OFFSET, 32'h0, 4'hF);
    set_req(1, 1'b0, CLINT_BASE + MTIME_OFFSET + 32'h4, 32'h0, 4'hF);
`ifdef CLINT_ARB_LOCK_EN
    lock_i = 4'b0001;
    order7 = '{0, 0, 0, 0, 1};
`else
    order7 = '{0, 1, 0, 1};
`endif
    foreach (order7[i]) expect_resp(order7[i], 1'b0, 32'h0000_7777);
    req_i = 4'b0011;
    foreach (order7[i]) wait_ready(order7[i], t);
    step();
    req_i = '0;
`ifdef CLINT_ARB_LOCK_EN
    lock_i = '0;
`endif

    repeat (4) step();
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clint_arbiter.md
Name: clint_arbiter

Overview:
- Shares the single CLINT memory-mapped slave port between NUM_REQ requesters (per-core load/store units, debug module).
- Fair round-robin grant.
- Latches the winner's transaction and drives it to the CLINT until mem_ready_i.
- Returns read data and a per-requester ready; a watchdog converts a non-responding access (unmapped CLINT address) into an error response instead of hanging the bus.

Parameters:
- NUM_REQ, 4, number of requesters (>=2)
- TIMEOUT_CYCLES, 16, ACCESS cycles allowed without mem_ready_i before error response (>=2)
- IDX_W, $clog2(NUM_REQ), derived grant index width; not user-overridden

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NUM_REQ  per-requester request, held until ready_o
- we_i  in  NUM_REQ  per-requester write enable
- addr_i  in  NUM_REQ*32  packed addresses, requester k at [32k+31:32k]
- wdata_i  in  NUM_REQ*32  packed write data
- be_i  in  NUM_REQ*4  packed byte enables
- ready_o  out  NUM_REQ  one-hot, one-cycle completion pulse
- err_o  out  NUM_REQ  one-hot, valid with ready_o, 1 = timed out
- rdata_o  out  32  shared read data, valid when any ready_o is high
- mem_req_o  out  1  to CLINT mem_req_i
- mem_we_o  out  1  to CLINT mem_we_i
- mem_addr_o  out  32  to CLINT mem_addr_i
- mem_wdata_o  out  32  to CLINT mem_wdata_i
- mem_be_o  out  4  to CLINT mem_be_i
- mem_rdata_i  in  32  from CLINT mem_rdata_o
- mem_ready_i  in  1  from CLINT mem_ready_o; may be combinational on mem_req_o

Behaviour:
- Reset values:
  - state=IDLE, rr pointer=0, timeout counter=0.
  - All outputs 0: mem_req_o, mem_*_o, ready_o, err_o, rdata_o.
- FSM IDLE:
  - If any req_i, pick the first requester set at or after the pointer, wrapping modulo NUM_REQ.
  - Register grant idx and latch that requester's we/addr/wdata/be.
  - Pointer <= idx+1 (wraps to 0 at NUM_REQ-1); go to ACCESS.
  - No req: stay in IDLE, pointer unchanged.
- FSM ACCESS:
  - mem_req_o=1; mem_* driven from latched fields only (stable for the whole access).
  - mem_ready_i=1: capture mem_rdata_i (0 on writes), err=0, go to RESP.
  - Otherwise the counter increments. At count TIMEOUT_CYCLES-1 without ready: rdata=0, err=1, go to RESP.
- FSM RESP:
  - mem_req_o=0; ready_o[idx]=1, err_o[idx]=err, rdata_o=captured value, for exactly one cycle.
  - Clear counter; go to IDLE.
- Latency: req_i sampled in IDLE at cycle 0 -> mem_req_o cycle 1 -> ready_o cycle 2 (zero-wait CLINT). Throughput: one access per 3 cycles.
- Requester protocol:
  - Hold req_i and its fields until the ready_o pulse; drop req_i the cycle after.
  - A req_i still high in IDLE after RESP counts as a new request.
- req_i dropped during ACCESS is a protocol violation; the access still completes and ready_o still pulses.
- Simultaneous requests: exactly one grant. A requester continuously requesting waits at most NUM_REQ-1 other grants.
- rst_i in any state: at that edge, state=IDLE, mem_req_o=0, ready_o=0. The in-flight access is abandoned with no response; the pointer returns to 0.
- ready_o and err_o are never multi-hot; mem_req_o is never high outside ACCESS.

Optional Feature:
- Macro: CLINT_ARB_LOCK_EN.
- With the macro defined:
  - Adds input lock_i [NUM_REQ].
  - If lock_i[idx] is high in RESP and req_i[idx] is high the cycle after RESP, the FSM re-grants idx from IDLE regardless of the pointer, and the pointer is not advanced.
  - This gives atomic mtime hi/lo/hi or mtimecmp 3-write sequences.
  - Lock is ignored after 4 consecutive locked grants, when the normal rr pick applies.
- Without the macro: no lock_i port; pure round-robin.

Decomposition:
- Shared package clint_pkg:
  - state enum (IDLE, ACCESS, RESP).
  - CLINT_BASE, MSIP_OFFSET, MTIMECMP_OFFSET, MTIME_OFFSET constants.
  - Default TIMEOUT_CYCLES.
  - Max lock burst constant (4).
- Sub-module rr_arbiter:
  - NUM_REQ-wide request vector in; one-hot grant + index out.
  - Owns the pointer register with an advance strobe; reusable for the PLIC gateway.

Test Plan:
- Single request, requester 2 reads 0x0200_BFF8, CLINT mem_rdata=0x0000_1234 -> mem_req_o cycle 1, ready_o=4'b0100 cycle 2, rdata_o=0x0000_1234, err_o=0.
- req_i=4'b1111 held continuously from reset -> grant order 0,1,2,3,0; each ready_o exactly 3 cycles apart.
- Write by requester 1 to addr 0x0200_8000 (CLINT never readies), TIMEOUT_CYCLES=16 -> mem_req_o high for exactly 16 cycles, then ready_o[1]=1, err_o[1]=1, rdata_o=0.
- rst_i asserted in the second ACCESS cycle of a grant to requester 3 -> next cycle mem_req_o=0, no ready_o; after release, with req_i=4'b1001, requester 0 is granted first.
- CLINT_ARB_LOCK_EN: requester 0 locked, req_i=4'b0011 -> grants 0,0,0,0 then 1. Without lock_i -> 0,1,0,1.
- Fields of requester 0 change during ACCESS -> mem_addr_o, mem_wdata_o and mem_be_o keep the latched values.
